// File: rtl/lab1_gate_sweeper.sv
// Walks the lab 1 gate block through all four input vectors, samples its
// AND/OR/NOT outputs after a settle window and reports per-vector failures.
module lab1_gate_sweeper #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       obsAND,
    input  logic       obsOR,
    input  logic       obsNOT,
    output logic       drvA,
    output logic       drvB,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] errCount,
    output logic [3:0] failMask
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [1:0] vec, vec_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] mask_nxt;
    logic [2:0] err_nxt;
    logic [2:0] exp_obs;
    logic       mismatch;

    // Case inequality so an X/Z on any observed output is treated as a fail.
    assign exp_obs  = {vec[1] & vec[0], vec[1] | vec[0], ~vec[1]};
    assign mismatch = ({obsAND, obsOR, obsNOT} !== exp_obs);

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        cnt_nxt   = cnt;
        mask_nxt  = failMask;
        err_nxt   = errCount;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    vec_nxt   = 2'd0;
                    cnt_nxt   = CNT_LOAD;
                    mask_nxt  = 4'b0000;
                    err_nxt   = 3'd0;
                end
            end
            DRIVE: begin
                if (cnt == 4'd0) state_nxt = SAMPLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            SAMPLE: begin
                mask_nxt[vec] = mismatch;
                err_nxt       = errCount + 3'(mismatch);
                if (vec == 2'd3) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = DRIVE;
                    vec_nxt   = vec + 2'd1;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            vec      <= 2'd0;
            cnt      <= 4'd0;
            failMask <= 4'b0000;
            errCount <= 3'd0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            cnt      <= cnt_nxt;
            failMask <= mask_nxt;
            errCount <= err_nxt;
        end
    end

    // vec is 0 in IDLE and stays at 3 in DONE, so it drives the gate inputs directly.
    assign drvA = vec[1];
    assign drvB = vec[0];
    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (errCount == 3'd0);

endmodule

// File: tb/tb_lab1_gate_sweeper.sv
// Scoreboard bench: two sweepers (SETTLE=2 with a fault-injectable gate model,
// SETTLE=1 with a correct one); monitors pop expected drive/result entries.
module tb_lab1_gate_sweeper;

    typedef struct {
        logic [3:0] fm;
        logic [2:0] ec;
        logic       ps;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start0, start1;
    int   mode;
    int   cyc = 0;
    int   total = 0, bad = 0;

    logic       drv_a0, drv_b0, busy0, done0, pass0, and0, or0, not0;
    logic [2:0] err0;
    logic [3:0] fm0;
    logic       drv_a1, drv_b1, busy1, done1, pass1, and1, or1, not1;
    logic [2:0] err1;
    logic [3:0] fm1;

    // mode 0: correct gates, 1: OR stuck at 0, 2: NOT fed from inB
    assign and0 = drv_a0 & drv_b0;
    assign or0  = (mode == 1) ? 1'b0 : (drv_a0 | drv_b0);
    assign not0 = (mode == 2) ? ~drv_b0 : ~drv_a0;
    assign and1 = drv_a1 & drv_b1;
    assign or1  = drv_a1 | drv_b1;
    assign not1 = ~drv_a1;

    lab1_gate_sweeper #(.SETTLE(2)) dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .obsAND(and0), .obsOR(or0), .obsNOT(not0),
        .drvA(drv_a0), .drvB(drv_b0), .busy(busy0), .done(done0), .pass(pass0),
        .errCount(err0), .failMask(fm0)
    );

    lab1_gate_sweeper #(.SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .obsAND(and1), .obsOR(or1), .obsNOT(not1),
        .drvA(drv_a1), .drvB(drv_b1), .busy(busy1), .done(done1), .pass(pass1),
        .errCount(err1), .failMask(fm1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    exp_t       rq0[$], rq1[$];
    logic [1:0] dq0[$], dq1[$];

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Push the expected drive sequence and result for a start sampled on the next edge.
    task automatic push_exp(int d, logic [3:0] fm, logic [2:0] ec, logic ps);
        int   s;
        exp_t r;
        s = (d == 0) ? 2 : 1;
        r.fm = fm; r.ec = ec; r.ps = ps; r.cyc = cyc + 1 + 4 * (s + 1);
        for (int v = 0; v < 4; v++)
            for (int k = 0; k <= s; k++)
                if (d == 0) dq0.push_back(2'(v)); else dq1.push_back(2'(v));
        if (d == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    task automatic sweep(int d, logic [3:0] fm, logic [2:0] ec, logic ps);
        @(negedge clk);
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        push_exp(d, fm, ec, ps);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Monitors
    logic       done0_q = 1'b0, done1_q = 1'b0;
    logic [1:0] e0, e1;
    exp_t       r0, r1;

    always @(negedge clk) begin
        if (busy0) begin
            if (dq0.size() == 0) chk("drv0_unexpected", 1, 0);
            else begin e0 = dq0.pop_front(); chk("drv0_seq", {drv_a0, drv_b0}, e0); end
        end
        if (done0 && !done0_q) begin
            if (rq0.size() == 0) chk("res0_unexpected", 1, 0);
            else begin
                r0 = rq0.pop_front();
                chk("res0_mask", fm0, r0.fm);
                chk("res0_err", err0, r0.ec);
                chk("res0_pass", pass0, r0.ps);
                chk("res0_cycle", cyc, r0.cyc);
                chk("res0_drv_hold", {drv_a0, drv_b0}, 3);
            end
        end
        done0_q <= done0;
    end

    always @(negedge clk) begin
        if (busy1) begin
            if (dq1.size() == 0) chk("drv1_unexpected", 1, 0);
            else begin e1 = dq1.pop_front(); chk("drv1_seq", {drv_a1, drv_b1}, e1); end
        end
        if (done1 && !done1_q) begin
            if (rq1.size() == 0) chk("res1_unexpected", 1, 0);
            else begin
                r1 = rq1.pop_front();
                chk("res1_mask", fm1, r1.fm);
                chk("res1_err", err1, r1.ec);
                chk("res1_pass", pass1, r1.ps);
                chk("res1_cycle", cyc, r1.cyc);
            end
        end
        done1_q <= done1;
    end

    initial begin
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        start0 = 1'b1;                       // reset must win over start
        @(negedge clk);
        chk("reset0_outputs", {drv_a0, drv_b0, busy0, done0, pass0, err0, fm0}, 0);
        chk("reset1_outputs", {drv_a1, drv_b1, busy1, done1, pass1, err1, fm1}, 0);
        start0 = 1'b0;
        reset  = 1'b0;

        // correct gates
        mode = 0; sweep(0, 4'b0000, 3'd0, 1'b1); repeat (14) @(negedge clk);
        // OR stuck at 0
        mode = 1; sweep(0, 4'b1110, 3'd3, 1'b0); repeat (14) @(negedge clk);
        // NOT driven from inB
        mode = 2; sweep(0, 4'b0110, 3'd2, 1'b0); repeat (14) @(negedge clk);

        // start held for the whole sweep, then re-pulsed in DONE
        mode = 1;
        @(negedge clk);
        start0 = 1'b1;
        push_exp(0, 4'b1110, 3'd3, 1'b0);
        repeat (13) @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        chk("held_done_stays", done0, 1);
        sweep(0, 4'b1110, 3'd3, 1'b0);
        chk("restart_busy", busy0, 1);
        chk("restart_done_low", done0, 0);
        chk("restart_cleared", {err0, fm0}, 0);
        repeat (13) @(negedge clk);

        // reset at edge 7 of a sweep, restart at edge 9
        mode = 0;
        sweep(0, 4'b0000, 3'd0, 1'b1);       // returns after edge 0
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {drv_a0, drv_b0, busy0, done0, pass0, err0, fm0}, 0);
        dq0.delete();
        rq0.delete();
        reset = 1'b0;
        sweep(0, 4'b0000, 3'd0, 1'b1);
        repeat (14) @(negedge clk);

        // SETTLE=1 instance
        sweep(1, 4'b0000, 3'd0, 1'b1);
        repeat (10) @(negedge clk);

        chk("queues_drained", rq0.size() + rq1.size() + dq0.size() + dq1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lab1_gate_sweeper.md
# lab1_gate_sweeper

Sequential stimulus-and-check stage that sits directly upstream and downstream of the lab 1 gate block: it drives the gate block's `inA`/`inB` through all four input combinations, samples its `outAND`/`outOR`/`outNOT`, and compares each against the expected value. The result is reported as a per-vector fail mask, an error count and a pass flag. It lets the NOR-built gate set be checked on the board or in simulation without a hand-driven testbench.

## Interface
- `SETTLE`, default 2: number of cycles each vector is held before it is sampled. Legal range is 1..15, held in a 4-bit counter.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: begins a sweep when sampled high in IDLE or DONE.
- `obsAND` input, 1 bit: gate block `outAND`.
- `obsOR` input, 1 bit: gate block `outOR`.
- `obsNOT` input, 1 bit: gate block `outNOT`.
- `drvA` output, 1 bit: drives gate block `inA`.
- `drvB` output, 1 bit: drives gate block `inB`.
- `busy` output, 1 bit: high while in DRIVE or SAMPLE.
- `done` output, 1 bit: high in DONE. Held until the next `start` or `reset`.
- `pass` output, 1 bit: equals `done` AND `errCount`==0.
- `errCount` output, 3 bits: number of failing vectors, 0..4.
- `failMask` output, 4 bits: bit i set when vector i mismatched.

## Operation
- **Vector index:** vec (2 bits), with `drvA`=vec[1] and `drvB`=vec[0]. Order is 00, 01, 10, 11.
- **Expected values:** AND=A&B, OR=A|B, NOT=~A.
- **Vector fails** when any of the three observed outputs differs from its expected value. An X/Z on any observed output counts as a mismatch.
- **States:** IDLE, DRIVE, SAMPLE, DONE.
  - **IDLE:** `drvA`=`drvB`=0 and all flags are 0. When `start`=1: go to DRIVE, set vec=0, set settle counter cnt=SETTLE-1, clear `failMask`/`errCount`.
  - **DRIVE:** drive vec. If cnt==0, go to SAMPLE. Otherwise decrement cnt.
  - **SAMPLE:** compare the observed outputs in this cycle. On the edge, update `failMask`[vec] and increment `errCount` on a mismatch.
    - If vec==3, go to DONE.
    - Otherwise set vec=vec+1, cnt=SETTLE-1, and go to DRIVE.
  - **DONE:** `done`=1. `drvA`/`drvB` hold vector 11. When `start`=1, restart exactly as from IDLE; the results clear on that edge.
- **`start` in DRIVE/SAMPLE** is ignored and causes no restart.
- **`errCount`** always equals the popcount of `failMask`. It cannot overflow, since its maximum is 4.
- **All outputs are registered or decoded from registered state.** There is no combinational path from `obs*` to any output.

## Timing
- **Reset:** `reset`=1 at an edge forces IDLE, vec=0, cnt=0 and all outputs 0 (`drvA`, `drvB`, `busy`, `done`, `pass`, `errCount`=0, `failMask`=0000).
  - Reset takes priority over `start`.
  - Reset mid-sweep discards partial results.
- **Cycles per vector:** SETTLE cycles in DRIVE plus 1 cycle in SAMPLE, i.e. SETTLE+1.
- **Sweep length:** 4*(SETTLE+1) cycles with `busy`=1.
- **Latency:** with `start` sampled at edge 0, `busy` rises after edge 0, and `done`/`pass` rise after edge 4*(SETTLE+1). For SETTLE=2 this is edge 12.
- **Sampling point:** vector i is sampled at edge (i+1)*(SETTLE+1). The gate block therefore has SETTLE full cycles of settling before the sample.
- **`drvA`/`drvB`** change only on the edge that enters DRIVE for a new vector.
- **Start from DONE:** `done` falls and `busy` rises after the same edge.

## Test plan
- **Correct gate block, SETTLE=2:** pulse `start` at edge 0. Required:
  - `drvA`/`drvB` sequence 00, 01, 10, 11, each held for 3 cycles.
  - After edge 12: `done`=1, `pass`=1, `errCount`=0, `failMask`=0000.
- **`obsOR` stuck at 0:** required `failMask`=1110, `errCount`=3, `pass`=0, `done`=1 after edge 12.
- **`obsNOT` wired to inB (faulty):** vectors 01 and 10 fail. Required `failMask`=0110 and `errCount`=2.
- **`start` held high during the whole sweep:** no restart; `done` still at edge 12. Then re-pulse `start` in DONE. Required:
  - Results clear and `busy`=1 on the next cycle.
  - The second sweep finishes 12 cycles later with the same results.
- **`reset` asserted at edge 7 mid-sweep:** all outputs go to 0 after edge 7. A new `start` at edge 9 gives `done` after edge 21.
- **SETTLE=1:** required `done` after edge 8, with each vector held for 2 cycles.
